// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_bus_arbiter
// Purpose : Round-robin owner of a shared memory-bus select mux. Registers a
//           one-hot grant plus the matching binary select, bounds how long an
//           unlocked owner may keep the bus while others wait, and lets the
//           current owner lock the bus for atomic access sequences.
// Ports   : clk_i    - rising-edge clock
//           rst_n_i  - asynchronous assert / synchronous release, active low
//           req_i    - per-requester level-sensitive bus request
//           lock_i   - per-requester lock (only the current owner's bit counts)
//           grant_o  - registered one-hot grant, all-zero when the bus is free
//           sel_o    - mux select, index of the current or last owner
//           busy_o   - high whenever grant_o is non-zero
// Revision: 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
  parameter int CHANNELS  = 4,
  parameter int SEL_WIDTH = 2,
  parameter int MAX_HOLD  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [CHANNELS-1:0]  req_i,
  input  logic [CHANNELS-1:0]  lock_i,
  output logic [CHANNELS-1:0]  grant_o,
  output logic [SEL_WIDTH-1:0] sel_o,
  output logic                 busy_o
);

  localparam int c_hold_w = $clog2(MAX_HOLD);
  localparam logic [c_hold_w-1:0] c_hold_max = c_hold_w'(MAX_HOLD - 1);

  localparam logic [0:0] c_idle  = 1'b0;
  localparam logic [0:0] c_owned = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [CHANNELS-1:0]  grant_q, grant_d;
  logic [SEL_WIDTH-1:0] sel_q,   sel_d;
  logic [SEL_WIDTH-1:0] ptr_q,   ptr_d;
  logic [c_hold_w-1:0]  hold_q,  hold_d;

  logic                 w_found;
  logic [SEL_WIDTH-1:0] w_win;
  logic [SEL_WIDTH:0]   w_idx;
  logic                 w_owner_req;
  logic                 w_owner_lock;
  logic                 w_others;
  logic                 w_sat;
  logic                 w_release;

  // Rotating priority scan: first requester at or after ptr, wrapping.
  // w_idx carries one extra bit so ptr + offset never overflows before wrap.
  always_comb begin : p_scan
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_idx = {1'b0, ptr_q} + (SEL_WIDTH+1)'(i);
      if (w_idx >= (SEL_WIDTH+1)'(CHANNELS)) begin
        w_idx = w_idx - (SEL_WIDTH+1)'(CHANNELS);
      end
      if (!w_found && req_i[w_idx[SEL_WIDTH-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[SEL_WIDTH-1:0];
      end
    end
  end

  // Release terms. Only the owner's lock bit is ever looked at, so other
  // requesters cannot block a timeout handoff.
  assign w_owner_req  = req_i[sel_q];
  assign w_owner_lock = lock_i[sel_q];
  assign w_others     = |(req_i & ~grant_q);
  assign w_sat        = (hold_q == c_hold_max);
  assign w_release    = !w_owner_req || (w_sat && !w_owner_lock && w_others);

  // State register (all registered outputs live here too).
  always_ff @(posedge clk_i or negedge rst_n_i) begin : p_state
    if (!rst_n_i) begin
      state_q <= c_idle;
      grant_q <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state logic.
  always_comb begin : p_next
    state_d = state_q;
    case (state_q)
      c_idle:  if (w_found)   state_d = c_owned;
      c_owned: if (w_release) state_d = c_idle;
      default: state_d = c_idle;
    endcase
  end

  // Output/datapath next values. Release always goes through IDLE, which
  // gives the mandatory dead cycle between owners.
  always_comb begin : p_out
    grant_d = grant_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    case (state_q)
      c_idle: begin
        if (w_found) begin
          grant_d = {{(CHANNELS-1){1'b0}}, 1'b1} << w_win;
          sel_d   = w_win;
          hold_d  = '0;
        end
      end
      c_owned: begin
        if (w_release) begin
          grant_d = '0;
          hold_d  = '0;
          // sel keeps the last owner so the mux does not toggle while idle
          ptr_d   = (sel_q == SEL_WIDTH'(CHANNELS - 1)) ? '0 : sel_q + SEL_WIDTH'(1);
        end else if (!w_sat) begin
          hold_d = hold_q + c_hold_w'(1);
        end
      end
      default: begin
        grant_d = '0;
        hold_d  = '0;
      end
    endcase
  end

  assign grant_o = grant_q;
  assign sel_o   = sel_q;
  assign busy_o  = |grant_q;

endmodule
`default_nettype wire
